// File: rtl/procfixcba_in_fifo.sv
// Sample buffer feeding procfixcba: a registered head word backed by a
// circular store, popped when the processor drives req_in == 2'd1.
module procfixcba_in_fifo #(
    parameter int WIDTH = 31,
    parameter int AW    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    input  logic signed [WIDTH-1:0] s_data,
    output logic                    s_ready,
    input  logic [1:0]              req_in,
    output logic signed [WIDTH-1:0] in_data,
    output logic                    head_vld,
    output logic [AW:0]             count,
    input  logic                    clr_flags,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] head_q, head_d;
    logic             head_vld_q, head_vld_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             mem_we;
    logic             pop;
    logic             wr_ok;

    assign s_ready   = (count_q != CNT_FULL);
    assign in_data   = head_q;
    assign head_vld  = head_vld_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

    always_comb begin
        pop        = (req_in == 2'd1);
        wr_ok      = s_valid && s_ready;
        head_d     = head_q;
        head_vld_d = head_vld_q;
        count_d    = count_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        mem_we     = 1'b0;
        ovf_d      = clr_flags ? 1'b0 : ovf_q;
        udf_d      = clr_flags ? 1'b0 : udf_q;

        if (pop) begin
            if (count_q != '0) begin
                head_d     = mem[rd_q];
                head_vld_d = 1'b1;
                rd_d       = rd_q + PTR_ONE;
                if (wr_ok) begin
                    mem_we = 1'b1;
                    wr_d   = wr_q + PTR_ONE;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end else if (wr_ok) begin
                // Store is empty: the incoming sample goes straight to the head.
                head_d     = s_data;
                head_vld_d = 1'b1;
            end else begin
                head_vld_d = 1'b0;
                udf_d      = 1'b1;
            end
        end else if (wr_ok) begin
            if (!head_vld_q) begin
                head_d     = s_data;
                head_vld_d = 1'b1;
            end else begin
                mem_we  = 1'b1;
                wr_d    = wr_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
            end
        end

        if (s_valid && !s_ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            head_vld_q <= 1'b0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage array carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_procfixcba_in_fifo.sv
// Directed-vector and reference-queue bench for procfixcba_in_fifo.
module tb_procfixcba_in_fifo;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic signed [30:0] s_data;
    logic               s_ready;
    logic [1:0]         req_in;
    logic signed [30:0] in_data;
    logic               head_vld;
    logic [4:0]         count;
    logic               clr_flags;
    logic               overflow;
    logic               underflow;

    int errors = 0;
    int checks = 0;

    procfixcba_in_fifo #(.WIDTH(31), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .req_in   (req_in),
        .in_data  (in_data),
        .head_vld (head_vld),
        .count    (count),
        .clr_flags(clr_flags),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [30:0] sd;
        logic [1:0]  rq;
        logic        clr;
        logic [30:0] e_in;
        logic        e_vld;
        logic [4:0]  e_cnt;
        logic        e_rdy;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    function automatic vec_t mk(input logic sv, input int sd, input logic [1:0] rq,
                                input logic clr, input int ein, input logic evld,
                                input int ecnt, input logic erdy, input logic eovf,
                                input logic eudf);
        vec_t v;
        v.sv = sv; v.sd = 31'(sd); v.rq = rq; v.clr = clr;
        v.e_in = 31'(ein); v.e_vld = evld; v.e_cnt = 5'(ecnt);
        v.e_rdy = erdy; v.e_ovf = eovf; v.e_udf = eudf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 1'b0; s_data = '0; req_in = 2'd0; clr_flags = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_in_data", {1'b0, in_data}, 32'd0);
        chk("rst_head_vld", 32'(head_vld), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        rst = 1'b1;
    endtask

    vec_t vt[18];
    int   q[$];

    initial begin
        int sent;
        int cyc;
        int mcnt;
        logic do_pop;

        vt[0]  = mk(1, -5,          0, 0, -5,          1, 0, 1, 0, 0);
        vt[1]  = mk(1, 7,           0, 0, -5,          1, 1, 1, 0, 0);
        vt[2]  = mk(0, 0,           1, 0, 7,           1, 0, 1, 0, 0);
        vt[3]  = mk(1, -1073741824, 1, 0, -1073741824, 1, 0, 1, 0, 0);
        vt[4]  = mk(0, 0,           1, 0, -1073741824, 0, 0, 1, 0, 1);
        vt[5]  = mk(1, 4,           0, 0, 4,           1, 0, 1, 0, 1);
        vt[6]  = mk(0, 0,           2, 0, 4,           1, 0, 1, 0, 1);
        vt[7]  = mk(0, 0,           3, 0, 4,           1, 0, 1, 0, 1);
        vt[8]  = mk(0, 0,           0, 0, 4,           1, 0, 1, 0, 1);
        vt[9]  = mk(0, 0,           0, 1, 4,           1, 0, 1, 0, 0);
        vt[10] = mk(0, 0,           1, 1, 4,           0, 0, 1, 0, 1);
        vt[11] = mk(0, 0,           0, 0, 4,           0, 0, 1, 0, 1);
        vt[12] = mk(0, 0,           0, 1, 4,           0, 0, 1, 0, 0);
        vt[13] = mk(0, 0,           1, 0, 4,           0, 0, 1, 0, 1);
        vt[14] = mk(1, 12,          1, 1, 12,          1, 0, 1, 0, 0);
        vt[15] = mk(1, -2,          0, 0, 12,          1, 1, 1, 0, 0);
        vt[16] = mk(1, 3,           1, 0, -2,          1, 1, 1, 0, 0);
        vt[17] = mk(0, 0,           1, 0, 3,           1, 0, 1, 0, 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            s_valid = vt[i].sv; s_data = vt[i].sd; req_in = vt[i].rq; clr_flags = vt[i].clr;
            tick();
            chk($sformatf("v%0d_in_data", i), {1'b0, in_data}, {1'b0, vt[i].e_in});
            chk($sformatf("v%0d_head_vld", i), 32'(head_vld), 32'(vt[i].e_vld));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
            chk($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vt[i].e_udf));
        end
        idle();

        // Fill to capacity, overflow, then drain in order.
        do_reset();
        for (int v = 1; v <= 17; v++) begin
            s_valid = 1'b1; s_data = 31'(v);
            tick();
            chk($sformatf("fill%0d_count", v), 32'(count), 32'(v - 1));
            chk($sformatf("fill%0d_head", v), {1'b0, in_data}, 32'd1);
        end
        chk("full_s_ready", 32'(s_ready), 32'd0);
        s_data = 31'(99);
        tick();
        tick();
        s_valid = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        req_in = 2'd1;
        #1;
        chk("full_pop_s_ready", 32'(s_ready), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("pop%0d_in_data", k), {1'b0, in_data}, 32'(k + 1));
            chk($sformatf("pop%0d_count", k), 32'(count), 32'(16 - k));
            chk($sformatf("pop%0d_s_ready", k), 32'(s_ready), 32'd1);
        end
        tick();
        req_in = 2'd0;
        chk("pop17_head_vld", 32'(head_vld), 32'd0);
        chk("pop17_underflow", 32'(underflow), 32'd1);
        chk("pop17_in_data", {1'b0, in_data}, 32'd17);

        // Asynchronous reset in the middle of a cycle discards contents.
        for (int v = 0; v < 3; v++) begin
            s_valid = 1'b1; s_data = 31'(20 + v);
            tick();
        end
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_head_vld", 32'(head_vld), 32'd0);
        chk("midrst_in_data", {1'b0, in_data}, 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        tick();
        rst = 1'b1;
        s_valid = 1'b1; s_data = 31'(55);
        tick();
        idle();
        chk("postrst_in_data", {1'b0, in_data}, 32'd55);
        chk("postrst_count", 32'(count), 32'd0);
        chk("postrst_head_vld", 32'(head_vld), 32'd1);

        // Random-timed stream against a reference queue (head at front).
        do_reset();
        q.delete();
        sent = 0;
        cyc = 0;
        while ((sent < 100 || q.size() > 1) && cyc < 3000) begin
            mcnt = (q.size() > 0) ? q.size() - 1 : 0;
            s_valid = (sent < 100) && (mcnt < 16) && ($urandom_range(0, 9) < 6);
            s_data = 31'(1000 + sent);
            do_pop = (q.size() >= 2) && ($urandom_range(0, 9) < 4);
            if (do_pop) req_in = 2'd1;
            else        req_in = 2'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(2, 3));
            tick();
            if (do_pop) void'(q.pop_front());
            if (s_valid) begin
                q.push_back(1000 + sent);
                sent++;
            end
            chk("rnd_head_vld", 32'(head_vld), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_in_data", {1'b0, in_data}, {1'b0, 31'(q[0])});
                chk("rnd_count", 32'(count), 32'(q.size() - 1));
            end
            cyc++;
        end
        idle();
        chk("rnd_cycle_budget", 32'(cyc < 3000), 32'd1);
        chk("rnd_all_sent", 32'(sent), 32'd100);
        chk("rnd_overflow", 32'(overflow), 32'd0);
        chk("rnd_underflow", 32'(underflow), 32'd0);
        chk("rnd_last", {1'b0, in_data}, 32'd1099);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
